// File: rtl/vmvmb_seq.sv
// vmvmb_seq: sequential vector-matrix-vector multiply with bias.
// Computes A = Wx^T x + Wh^T h_prev + b one block of LANES outputs at a time.
// The weights stream in from an external memory with a one-cycle read latency.
// Each result block is presented on a valid/ready output port.
module vmvmb_seq #(
    parameter int IN_SIZE   = 100,
    parameter int OUT_SIZE  = 400,
    parameter int LANES     = 4,
    parameter int FRAC_BITS = 0,
    parameter int ACC_W     = 72,
    localparam int DATA_W   = 32,
    localparam int NBLK     = OUT_SIZE / LANES,
    localparam int ROW_W    = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1,
    localparam int BLK_W    = (NBLK > 1) ? $clog2(NBLK) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [IN_SIZE-1:0][DATA_W-1:0]   x,
    input  logic [IN_SIZE-1:0][DATA_W-1:0]   h_prev,
    input  logic [OUT_SIZE-1:0][DATA_W-1:0]  b,
    output logic                             w_rd_en,
    output logic                             w_sel,
    output logic [ROW_W-1:0]                 w_row,
    output logic [BLK_W-1:0]                 w_blk,
    input  logic [LANES-1:0][DATA_W-1:0]     w_rdata,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [LANES-1:0][DATA_W-1:0]     out_data,
    output logic [BLK_W-1:0]                 out_blk,
    output logic                             busy,
    output logic                             done
);

    generate
        if (OUT_SIZE % LANES != 0) begin : g_bad_lanes
            $error("vmvmb_seq: OUT_SIZE must be a multiple of LANES");
        end
        if (ACC_W < 64 + $clog2(2 * IN_SIZE + 1)) begin : g_bad_accw
            $error("vmvmb_seq: ACC_W too narrow to hold the full dot product");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, MAC_X, MAC_H, FLUSH, OUT, DONE} state_t;

    state_t                      state;
    logic [BLK_W-1:0]            j;
    logic                        flush_p;

    // Operand copies taken at start so later input changes cannot disturb a run.
    logic signed [DATA_W-1:0]    x_q [IN_SIZE];
    logic signed [DATA_W-1:0]    h_q [IN_SIZE];
    logic signed [DATA_W-1:0]    b_q [OUT_SIZE];

    // Read-return stage: describes the row whose weights sit on w_rdata this cycle.
    logic                        vld_p1;
    logic                        sel_p1;
    logic [ROW_W-1:0]            row_p1;

    logic signed [ACC_W-1:0]     acc     [LANES];
    logic signed [ACC_W-1:0]     acc_nxt [LANES];
    logic signed [63:0]          prod    [LANES];
    logic signed [DATA_W-1:0]    v_p1;

    // Bias seeded into the accumulator at the same binary point as the products.
    function automatic logic signed [ACC_W-1:0] bias_init(input logic signed [DATA_W-1:0] bv);
        logic signed [ACC_W-1:0] t;
        t = ACC_W'(bv);
        return t <<< FRAC_BITS;
    endfunction

    // Drop fraction bits (floor) and clamp into the 32-bit signed range.
    function automatic logic [DATA_W-1:0] sat32(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] s;
        s = a >>> FRAC_BITS;
        if (s[ACC_W-1:DATA_W-1] == '0 || s[ACC_W-1:DATA_W-1] == '1)
            return s[DATA_W-1:0];
        else if (s[ACC_W-1])
            return 32'h8000_0000;
        else
            return 32'h7FFF_FFFF;
    endfunction

    // Full-precision lane products for the row returned this cycle.
    always_comb begin
        v_p1 = sel_p1 ? h_q[row_p1] : x_q[row_p1];
        for (int k = 0; k < LANES; k++) begin
            prod[k]    = 64'($signed(w_rdata[k])) * 64'(v_p1);
            acc_nxt[k] = acc[k] + ACC_W'(prod[k]);
        end
    end

    // Sequencer, read issue, accumulation and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            j         <= '0;
            flush_p   <= 1'b0;
            vld_p1    <= 1'b0;
            sel_p1    <= 1'b0;
            row_p1    <= '0;
            w_rd_en   <= 1'b0;
            w_sel     <= 1'b0;
            w_row     <= '0;
            w_blk     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_blk   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            for (int k = 0; k < LANES; k++) acc[k] <= '0;
        end else begin
            // ---- issue stage -> return stage ----
            vld_p1 <= w_rd_en;
            sel_p1 <= w_sel;
            row_p1 <= w_row;
            done   <= 1'b0;

            // ---- return stage -> accumulator ----
            if (vld_p1) begin
                for (int k = 0; k < LANES; k++) acc[k] <= acc_nxt[k];
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        for (int i = 0; i < IN_SIZE; i++) begin
                            x_q[i] <= $signed(x[i]);
                            h_q[i] <= $signed(h_prev[i]);
                        end
                        for (int c = 0; c < OUT_SIZE; c++) b_q[c] <= $signed(b[c]);
                        for (int k = 0; k < LANES; k++) acc[k] <= bias_init($signed(b[k]));
                        j       <= '0;
                        w_rd_en <= 1'b1;
                        w_sel   <= 1'b0;
                        w_row   <= '0;
                        w_blk   <= '0;
                        busy    <= 1'b1;
                        state   <= MAC_X;
                    end
                end
                MAC_X: begin
                    if (w_row == ROW_W'(IN_SIZE - 1)) begin
                        w_sel <= 1'b1;
                        w_row <= '0;
                        state <= MAC_H;
                    end else begin
                        w_row <= w_row + 1'b1;
                    end
                end
                MAC_H: begin
                    if (w_row == ROW_W'(IN_SIZE - 1)) begin
                        w_rd_en <= 1'b0;
                        w_sel   <= 1'b0;
                        w_row   <= '0;
                        flush_p <= 1'b0;
                        state   <= FLUSH;
                    end else begin
                        w_row <= w_row + 1'b1;
                    end
                end
                FLUSH: begin
                    // First cycle lets the last row land in acc; second produces the block.
                    if (!flush_p) begin
                        flush_p <= 1'b1;
                    end else begin
                        for (int k = 0; k < LANES; k++) out_data[k] <= sat32(acc[k]);
                        out_blk   <= j;
                        out_valid <= 1'b1;
                        state     <= OUT;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (j == BLK_W'(NBLK - 1)) begin
                            busy  <= 1'b0;
                            state <= DONE;
                        end else begin
                            for (int k = 0; k < LANES; k++)
                                acc[k] <= bias_init(b_q[(int'(j) + 1) * LANES + k]);
                            j       <= j + 1'b1;
                            w_blk   <= j + 1'b1;
                            w_rd_en <= 1'b1;
                            w_sel   <= 1'b0;
                            w_row   <= '0;
                            state   <= MAC_X;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vmvmb_seq.sv
// Bench for vmvmb_seq: two instances (FRAC_BITS 0 and 8) share stimulus and a
// behavioural weight memory; results are compared with a plain-arithmetic model.
module tb_vmvmb_seq;
    localparam int N  = 4;
    localparam int M  = 8;
    localparam int P  = 4;
    localparam int NB = M / P;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, out_ready;
    logic [N-1:0][31:0] x, h_prev;
    logic [M-1:0][31:0] b;

    logic w_rd_en0, w_sel0, out_valid0, busy0, done0;
    logic [1:0] w_row0;
    logic [0:0] w_blk0, out_blk0;
    logic [P-1:0][31:0] w_rdata0, out_data0;

    logic w_rd_en1, w_sel1, out_valid1, busy1, done1;
    logic [1:0] w_row1;
    logic [0:0] w_blk1, out_blk1;
    logic [P-1:0][31:0] w_rdata1, out_data1;

    vmvmb_seq #(.IN_SIZE(N), .OUT_SIZE(M), .LANES(P), .FRAC_BITS(0), .ACC_W(72)) u0 (
        .clk(clk), .rst(rst), .start(start), .x(x), .h_prev(h_prev), .b(b),
        .w_rd_en(w_rd_en0), .w_sel(w_sel0), .w_row(w_row0), .w_blk(w_blk0),
        .w_rdata(w_rdata0), .out_valid(out_valid0), .out_ready(out_ready),
        .out_data(out_data0), .out_blk(out_blk0), .busy(busy0), .done(done0));

    vmvmb_seq #(.IN_SIZE(N), .OUT_SIZE(M), .LANES(P), .FRAC_BITS(8), .ACC_W(72)) u1 (
        .clk(clk), .rst(rst), .start(start), .x(x), .h_prev(h_prev), .b(b),
        .w_rd_en(w_rd_en1), .w_sel(w_sel1), .w_row(w_row1), .w_blk(w_blk1),
        .w_rdata(w_rdata1), .out_valid(out_valid1), .out_ready(out_ready),
        .out_data(out_data1), .out_blk(out_blk1), .busy(busy1), .done(done1));

    int wx[N][M], wh[N][M], xv[N], hv[N], bv[M];

    // Weight memory: data appears one cycle after the read strobe.
    always @(posedge clk) begin
        for (int k = 0; k < P; k++)
            w_rdata0[k] <= w_rd_en0 ? (w_sel0 ? wh[w_row0][int'(w_blk0)*P+k] : wx[w_row0][int'(w_blk0)*P+k]) : $urandom;
    end
    always @(posedge clk) begin
        for (int k = 0; k < P; k++)
            w_rdata1[k] <= w_rd_en1 ? (w_sel1 ? wh[w_row1][int'(w_blk1)*P+k] : wx[w_row1][int'(w_blk1)*P+k]) : $urandom;
    end

    typedef struct {
        logic [31:0]        wxv;
        logic [31:0]        whv;
        logic [N-1:0][31:0] xi;
        logic [N-1:0][31:0] hi;
        logic [M-1:0][31:0] bi;
        bit                 f8;
        logic [M-1:0][31:0] e;
    } vec_t;

    vec_t tbl[5];

    int chk_cnt = 0;
    int pass_cnt = 0;
    logic [31:0] res0[M], res1[M], exp0[M], exp1[M];
    int tv[NB], tx[NB];
    int t_done;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        chk_cnt++;
        if (act === expv) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    endtask

    // Reference: A[c] = sat(floor((sum Wx*x + sum Wh*h + (b<<F)) / 2^F)).
    function automatic logic [31:0] ref_elem(input int c, input int f);
        logic signed [79:0] s, p;
        s = 80'(bv[c]);
        s = s <<< f;
        for (int i = 0; i < N; i++) begin
            p = longint'(wx[i][c]) * longint'(xv[i]);
            s = s + p;
            p = longint'(wh[i][c]) * longint'(hv[i]);
            s = s + p;
        end
        s = s >>> f;
        if (s > 80'sd2147483647) return 32'h7FFF_FFFF;
        if (s < -80'sd2147483648) return 32'h8000_0000;
        return s[31:0];
    endfunction

    task automatic apply_inputs();
        for (int i = 0; i < N; i++) begin x[i] = xv[i]; h_prev[i] = hv[i]; end
        for (int c = 0; c < M; c++) b[c] = bv[c];
    endtask

    task automatic load_vec(input vec_t v);
        for (int i = 0; i < N; i++) begin
            for (int c = 0; c < M; c++) begin wx[i][c] = v.wxv; wh[i][c] = v.whv; end
            xv[i] = v.xi[i];
            hv[i] = v.hi[i];
        end
        for (int c = 0; c < M; c++) bv[c] = v.bi[c];
        apply_inputs();
    endtask

    task automatic model();
        for (int c = 0; c < M; c++) begin exp0[c] = ref_elem(c, 0); exp1[c] = ref_elem(c, 8); end
    endtask

    // mode 0: ready high; 1: random ready; 2: stall block 0 for 5 cycles.
    task automatic run(input string tag, input int mode, input bit poke);
        int cyc, stalls;
        bit d0, d1, pv, pr, rd_bad;
        logic [P-1:0][31:0] pdat;
        logic [0:0] pblk;
        for (int c = 0; c < M; c++) begin res0[c] = 32'h5A5A_5A5A; res1[c] = 32'h5A5A_5A5A; end
        for (int q = 0; q < NB; q++) begin tv[q] = -1; tx[q] = -1; end
        t_done = -1; d0 = 0; d1 = 0; pv = 0; pr = 0; rd_bad = 0; stalls = 0; cyc = 0;
        pdat = '0; pblk = '0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        while (!(d0 && d1) && cyc < 400) begin
            if (poke) begin
                start = (cyc == 3);
                if (cyc == 3) begin xv[0] = xv[0] + 7; xv[2] = -xv[2] + 1; apply_inputs(); end
            end
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom_range(0, 1));
                default: out_ready = !(out_valid0 && out_blk0 == 1'b0 && stalls < 5);
            endcase
            if (out_valid0 && !out_ready) stalls++;
            if (pv && !pr)
                chk({tag, " hold"}, {out_valid0, out_blk0, out_data0}, {1'b1, pblk, pdat});
            if (out_valid0 && w_rd_en0) rd_bad = 1;
            if (out_valid0 && tv[out_blk0] < 0) tv[out_blk0] = cyc;
            if (out_valid0 && out_ready) begin
                for (int k = 0; k < P; k++) res0[int'(out_blk0)*P+k] = out_data0[k];
                tx[out_blk0] = cyc;
            end
            if (out_valid1 && out_ready)
                for (int k = 0; k < P; k++) res1[int'(out_blk1)*P+k] = out_data1[k];
            if (done0) begin d0 = 1; t_done = cyc; end
            if (done1) d1 = 1;
            pv = out_valid0; pr = out_ready; pdat = out_data0; pblk = out_blk0;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk({tag, " finished"}, {62'd0, d0, d1}, 64'd3);
        chk({tag, " no read during OUT"}, 64'(rd_bad), 64'd0);
        chk({tag, " first valid cycle"}, 64'(tv[0]), 64'(2*N+2));
        chk({tag, " next block gap"}, 64'(tv[1] - tx[0]), 64'(2*N+3));
        if (mode == 0) chk({tag, " done cycle"}, 64'(t_done), 64'(NB*(2*N+3)+1));
        for (int c = 0; c < M; c++) begin
            chk($sformatf("%s f0 A[%0d]", tag, c), 64'(res0[c]), 64'(exp0[c]));
            chk($sformatf("%s f8 A[%0d]", tag, c), 64'(res1[c]), 64'(exp1[c]));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected summary");
        $fatal(1);
    end

    initial begin
        bit bad;
        tbl[0] = '{32'd1, 32'd1, {32'd4, 32'd3, 32'd2, 32'd1}, '0,
                   {32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0}, 1'b0,
                   {32'd17, 32'd16, 32'd15, 32'd14, 32'd13, 32'd12, 32'd11, 32'd10}};
        tbl[1] = '{32'h7FFFFFFF, 32'h7FFFFFFF, {N{32'h7FFFFFFF}}, {N{32'h7FFFFFFF}}, '0, 1'b0,
                   {M{32'h7FFFFFFF}}};
        tbl[2] = '{32'h7FFFFFFF, 32'h7FFFFFFF, {N{32'h80000001}}, {N{32'h80000001}}, '0, 1'b0,
                   {M{32'h80000000}}};
        tbl[3] = '{32'd2, -32'sd3, {32'd0, 32'd5, -32'sd1, 32'd1}, {N{32'd2}},
                   {-32'sd7000, -32'sd6000, -32'sd5000, -32'sd4000, -32'sd3000, -32'sd2000, -32'sd1000, 32'd0},
                   1'b0,
                   {-32'sd7014, -32'sd6014, -32'sd5014, -32'sd4014, -32'sd3014, -32'sd2014, -32'sd1014, -32'sd14}};
        tbl[4] = '{32'd384, 32'd0, {N{32'd256}}, '0, {M{32'd128}}, 1'b1, {M{32'd1664}}};

        rst = 1'b1; start = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < N; i++) begin xv[i] = $urandom; hv[i] = $urandom; end
        for (int c = 0; c < M; c++) bv[c] = $urandom;
        apply_inputs();
        repeat (3) @(negedge clk);
        chk("reset outputs f0", {out_valid0, busy0, done0, w_rd_en0, w_sel0, w_row0, w_blk0, out_blk0, out_data0},
            '0);
        chk("reset outputs f8", {out_valid1, busy1, done1, w_rd_en1, w_sel1, w_row1, w_blk1, out_blk1, out_data1},
            '0);
        rst = 1'b0;

        for (int t = 0; t < 5; t++) begin
            load_vec(tbl[t]);
            model();
            run($sformatf("vec%0d", t), 0, 1'b0);
            for (int c = 0; c < M; c++)
                chk($sformatf("vec%0d table A[%0d]", t, c),
                    64'(tbl[t].f8 ? res1[c] : res0[c]), 64'(tbl[t].e[c]));
        end

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < N; i++) begin
                for (int c = 0; c < M; c++) begin
                    wx[i][c] = (r == 0) ? int'($urandom_range(0, 2000)) - 1000 :
                               (r == 1) ? int'($urandom_range(0, 2097152)) - 1048576 : int'($urandom);
                    wh[i][c] = (r == 0) ? int'($urandom_range(0, 2000)) - 1000 :
                               (r == 1) ? int'($urandom_range(0, 2097152)) - 1048576 : int'($urandom);
                end
                xv[i] = (r == 0) ? int'($urandom_range(0, 2000)) - 1000 : int'($urandom);
                hv[i] = (r == 0) ? int'($urandom_range(0, 2000)) - 1000 : int'($urandom);
            end
            for (int c = 0; c < M; c++) bv[c] = (r == 2) ? int'($urandom) : int'($urandom_range(0, 200000)) - 100000;
            apply_inputs();
            model();
            run($sformatf("rand%0d", r), 1, 1'b0);
        end

        load_vec(tbl[0]);
        model();
        run("stall", 2, 1'b0);

        load_vec(tbl[3]);
        model();
        run("restart ignored", 0, 1'b1);

        load_vec(tbl[0]);
        model();
        out_ready = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid reset outputs", {out_valid0, busy0, w_rd_en0, out_valid1, busy1, w_rd_en1}, '0);
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid0 || done0 || busy0 || w_rd_en0 || out_valid1 || done1) bad = 1;
        end
        chk("mid reset quiet", 64'(bad), 64'd0);
        run("after reset", 0, 1'b0);
        for (int c = 0; c < M; c++)
            chk($sformatf("after reset table A[%0d]", c), 64'(res0[c]), 64'(tbl[0].e[c]));

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
